mem_port_arbiter: RTL
=====================

Name: mem_port_arbiter

Overview:
- Shares one single-port, fixed-latency backing memory between the IF-stage instruction fetch and the MEM-stage load/store of the 5-stage pipelined CPU.
- Serialises accesses with a state machine and returns read data to each requester.
- Produces per-stage stall signals that the pipeline uses to freeze PC and the pipeline registers while an access is outstanding.

Parameters:
MEM_LATENCY, 4, cycles the backing memory needs with address and controls held stable; legal range 1..15
CNT_W, 4, width of the latency counter; must hold MEM_LATENCY-1

Ports:
clk  input  1  clock; all state updates on rising edge
reset  input  1  synchronous, active-high reset
if_req  input  1  instruction fetch request; held until if_done
if_addr  input  32  fetch address (current PC)
if_rdata  output  32  fetched instruction; valid while if_done=1, held afterwards
if_done  output  1  one-cycle completion pulse for fetch
d_read  input  1  load request; held until d_done
d_write  input  1  store request; held until d_done
d_addr  input  32  load/store address (ALU result in MEM stage)
d_wdata  input  32  store data
d_rdata  output  32  load data; valid while d_done=1, held afterwards
d_done  output  1  one-cycle completion pulse for data access
mem_addr  output  32  address to backing memory
mem_wdata  output  32  write data to backing memory
mem_read  output  1  read strobe to backing memory
mem_write  output  1  write strobe to backing memory
mem_rdata  input  32  read data from backing memory; valid in the last BUSY cycle
stall_if  output  1  freeze PC and IF/ID
stall_mem  output  1  freeze all pipeline registers up to and including EX/MEM

Behaviour:
- States: IDLE, BUSY, DONE. Registers: state, cnt, owner (0=IF, 1=data), last_owner, latched addr/wdata/is_write, if_rdata, d_rdata.
- Reset (synchronous):
  - State goes to IDLE; cnt=0; last_owner=IF, so data wins the first tie.
  - if_rdata=0, d_rdata=0; if_done=d_done=0; mem_read=mem_write=0; mem_addr=mem_wdata=0.
  - Reset mid-access aborts the access. Strobes drop in the first cycle after the reset edge, and no done pulse is issued.
- IDLE:
  - Data pending = d_read|d_write.
  - If exactly one requester is pending, grant it.
  - If both are pending, grant the one that is not last_owner (round-robin).
  - On grant, latch addr, wdata and is_write (d_write wins if d_read&d_write are both set; that case leaves d_rdata unchanged). Set cnt=MEM_LATENCY-1, update owner and last_owner, go to BUSY.
  - With no request, stay in IDLE. All mem_* outputs are 0.
- BUSY:
  - mem_addr and mem_wdata are driven from the latched values.
  - mem_read=!is_write and mem_write=is_write, both held constant for exactly MEM_LATENCY cycles.
  - While cnt!=0, decrement cnt.
  - When cnt==0: if this is a read, capture mem_rdata into if_rdata or d_rdata according to owner, then go to DONE.
- DONE:
  - Lasts one cycle. Strobes are 0. Pulse if_done or d_done according to owner, then return to IDLE.
  - New requests are sampled only in IDLE, so there is one bubble cycle between back-to-back accesses.
- Latency: a request sampled in IDLE at cycle 0 occupies BUSY in cycles 1..MEM_LATENCY, and its done is high in cycle MEM_LATENCY+1.
- Request dropped during BUSY (e.g. a flush): the access still completes and done still pulses. A store is never cancelled once granted.
- Stall outputs (combinational):
  - stall_if = if_req & !if_done.
  - stall_mem = (d_read|d_write) & !d_done.
  - The pipeline ORs stall_mem into stall_if externally.
- Both done signals are never high in the same cycle.
- rdata registers change only on a read completion of their owner.

Test Plan:
- MEM_LATENCY=4, if_req=1, addr 0x10, mem returns 0x00500093 → mem_read=1 in cycles 1-4, if_done=1 and if_rdata=0x00500093 in cycle 5, stall_if=1 in cycles 0-4.
- d_write=1, d_addr=0x20, d_wdata=0xDEADBEEF → mem_write=1 with those values for exactly 4 cycles; d_done pulses in cycle 5; d_rdata unchanged.
- if_req and d_read both asserted from reset → data granted first. Then IF is granted at the next IDLE (cycle 6), and if_done arrives in cycle 11.
- MEM_LATENCY=1 with back-to-back fetches to 0x0 and 0x4 → each fetch takes 3 cycles (IDLE, BUSY, DONE); if_done is high in cycles 2 and 5.
- Reset asserted in the 2nd BUSY cycle of a load → strobes are 0 in the following cycle, no d_done, d_rdata=0, state is IDLE.
- if_req dropped during BUSY → if_done still pulses once; no new access is started until a request is seen in IDLE.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the pipeline front end (fetch and load/store
// requesters), the memory arbiter and the single-port backing memory.
interface mem_port_arbiter_if;
    // Instruction fetch side
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_done;
    // Load/store side
    logic        d_read;
    logic        d_write;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [31:0] d_rdata;
    logic        d_done;
    // Backing memory side
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_rdata;
    // Pipeline freeze controls
    logic        stall_if;
    logic        stall_mem;

    // Arbiter view
    modport slave (
        input  if_req, if_addr, d_read, d_write, d_addr, d_wdata, mem_rdata,
        output if_rdata, if_done, d_rdata, d_done,
               mem_addr, mem_wdata, mem_read, mem_write,
               stall_if, stall_mem
    );

    // Requesters plus memory view
    modport master (
        output if_req, if_addr, d_read, d_write, d_addr, d_wdata, mem_rdata,
        input  if_rdata, if_done, d_rdata, d_done,
               mem_addr, mem_wdata, mem_read, mem_write,
               stall_if, stall_mem
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one fixed-latency single-port memory between instruction fetch and
// data load/store. Accesses are serialised IDLE -> BUSY -> DONE; address and
// strobes are held for MEM_LATENCY cycles, read data is captured in the last
// BUSY cycle and a one-cycle done pulse goes back to the owner.
module mem_port_arbiter #(
    parameter int MEM_LATENCY = 4,
    parameter int CNT_W       = 4
) (
    input  logic              clk,
    input  logic              reset,
    mem_port_arbiter_if.slave bus
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_e;

    localparam logic             OWNER_IF = 1'b0;
    localparam logic             OWNER_D  = 1'b1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LATENCY - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               owner_q, owner_d;
    logic               last_owner_q, last_owner_d;
    logic               is_write_q, is_write_d;
    logic [31:0]        mem_addr_q, mem_addr_d;
    logic [31:0]        mem_wdata_q, mem_wdata_d;
    logic               mem_read_q, mem_read_d;
    logic               mem_write_q, mem_write_d;
    logic [31:0]        if_rdata_q, if_rdata_d;
    logic [31:0]        d_rdata_q, d_rdata_d;
    logic               if_done_q, if_done_d;
    logic               d_done_q, d_done_d;

    logic               d_pend;
    logic               pick_data;

    // A store wins over a load if both are raised, so any data request counts.
    assign d_pend    = bus.d_read | bus.d_write;
    // Data is granted when alone, or on a tie when fetch went last.
    assign pick_data = d_pend & (~bus.if_req | (last_owner_q == OWNER_IF));

    // Next-state logic for the access sequencer and its registered outputs.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        is_write_d   = is_write_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        mem_read_d   = mem_read_q;
        mem_write_d  = mem_write_q;
        if_rdata_d   = if_rdata_q;
        d_rdata_d    = d_rdata_q;
        if_done_d    = 1'b0;
        d_done_d     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (d_pend | bus.if_req) begin
                    owner_d      = pick_data;
                    last_owner_d = pick_data;
                    cnt_d        = CNT_LOAD;
                    state_d      = S_BUSY;
                    if (pick_data) begin
                        mem_addr_d  = bus.d_addr;
                        mem_wdata_d = bus.d_wdata;
                        is_write_d  = bus.d_write;
                        mem_read_d  = ~bus.d_write;
                        mem_write_d = bus.d_write;
                    end else begin
                        mem_addr_d  = bus.if_addr;
                        mem_wdata_d = 32'h0000_0000;
                        is_write_d  = 1'b0;
                        mem_read_d  = 1'b1;
                        mem_write_d = 1'b0;
                    end
                end else begin
                    mem_addr_d  = 32'h0000_0000;
                    mem_wdata_d = 32'h0000_0000;
                    mem_read_d  = 1'b0;
                    mem_write_d = 1'b0;
                end
            end
            S_BUSY: begin
                if (cnt_q != CNT_ZERO) begin
                    cnt_d = cnt_q - CNT_ONE;
                end else begin
                    // Last BUSY cycle: memory data is valid now.
                    if (!is_write_q) begin
                        if (owner_q == OWNER_D) begin
                            d_rdata_d = bus.mem_rdata;
                        end else begin
                            if_rdata_d = bus.mem_rdata;
                        end
                    end else begin
                        d_rdata_d = d_rdata_q;
                    end
                    if (owner_q == OWNER_D) begin
                        d_done_d = 1'b1;
                    end else begin
                        if_done_d = 1'b1;
                    end
                    mem_addr_d  = 32'h0000_0000;
                    mem_wdata_d = 32'h0000_0000;
                    mem_read_d  = 1'b0;
                    mem_write_d = 1'b0;
                    state_d     = S_DONE;
                end
            end
            S_DONE: begin
                // Bubble cycle; requests are only looked at from IDLE.
                state_d = S_IDLE;
            end
            default: begin
                mem_addr_d  = 32'h0000_0000;
                mem_wdata_d = 32'h0000_0000;
                mem_read_d  = 1'b0;
                mem_write_d = 1'b0;
                state_d     = S_IDLE;
            end
        endcase
    end

    // State registers; reset aborts any access in flight without a done pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            cnt_q        <= CNT_ZERO;
            owner_q      <= OWNER_IF;
            last_owner_q <= OWNER_IF;
            is_write_q   <= 1'b0;
            mem_addr_q   <= 32'h0000_0000;
            mem_wdata_q  <= 32'h0000_0000;
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
            if_rdata_q   <= 32'h0000_0000;
            d_rdata_q    <= 32'h0000_0000;
            if_done_q    <= 1'b0;
            d_done_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
            is_write_q   <= is_write_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            mem_read_q   <= mem_read_d;
            mem_write_q  <= mem_write_d;
            if_rdata_q   <= if_rdata_d;
            d_rdata_q    <= d_rdata_d;
            if_done_q    <= if_done_d;
            d_done_q     <= d_done_d;
        end
    end

    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.mem_read  = mem_read_q;
    assign bus.mem_write = mem_write_q;
    assign bus.if_rdata  = if_rdata_q;
    assign bus.d_rdata   = d_rdata_q;
    assign bus.if_done   = if_done_q;
    assign bus.d_done    = d_done_q;

    // Freeze a stage while its request is up and not completing this cycle.
    assign bus.stall_if  = bus.if_req & ~if_done_q;
    assign bus.stall_mem = d_pend & ~d_done_q;
endmodule
